// File: rtl/cxu_l2_initiator_if.sv
// Host command/result and CXU-L2 request/response bundle for the L2 initiator.
// master = the initiator itself, slave = host plus responder tree.
interface cxu_l2_initiator_if #(
    parameter int N_CXUS    = 2,
    parameter int N_STATES  = 1,
    parameter int FUNC_ID_W = 10,
    parameter int DATA_W    = 32,
    parameter int ROB_DEPTH = 4
);
    localparam int CXU_ID_W   = (N_CXUS > 1) ? $clog2(N_CXUS) : 1;
    localparam int STATE_ID_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;
    localparam int ID_W       = $clog2(ROB_DEPTH);

    logic                  cmd_valid, cmd_ready;
    logic [CXU_ID_W-1:0]   cmd_cxu;
    logic [STATE_ID_W-1:0] cmd_state;
    logic [FUNC_ID_W-1:0]  cmd_func;
    logic [DATA_W-1:0]     cmd_data0, cmd_data1;

    logic                  res_valid, res_ready, res_status;
    logic [DATA_W-1:0]     res_data;

    logic                  req_valid, req_ready;
    logic [ID_W-1:0]       req_id;
    logic [CXU_ID_W-1:0]   req_cxu;
    logic [STATE_ID_W-1:0] req_state;
    logic [FUNC_ID_W-1:0]  req_func;
    logic [DATA_W-1:0]     req_data0, req_data1;

    logic                  resp_valid, resp_ready, resp_status;
    logic [ID_W-1:0]       resp_id;
    logic [DATA_W-1:0]     resp_data;

    logic                  err_unexpected;

    modport master (
        input  cmd_valid, cmd_cxu, cmd_state, cmd_func, cmd_data0, cmd_data1,
        output cmd_ready,
        output res_valid, res_status, res_data,
        input  res_ready,
        output req_valid, req_id, req_cxu, req_state, req_func, req_data0, req_data1,
        input  req_ready,
        input  resp_valid, resp_id, resp_status, resp_data,
        output resp_ready,
        output err_unexpected
    );

    modport slave (
        output cmd_valid, cmd_cxu, cmd_state, cmd_func, cmd_data0, cmd_data1,
        input  cmd_ready,
        input  res_valid, res_status, res_data,
        output res_ready,
        input  req_valid, req_id, req_cxu, req_state, req_func, req_data0, req_data1,
        output req_ready,
        output resp_valid, resp_id, resp_status, resp_data,
        input  resp_ready,
        input  err_unexpected
    );
endinterface

// File: rtl/cxu_l2_initiator.sv
// CXU-L2 initiator: tags host commands, absorbs out-of-order responses in a ROB, returns results in order.
// Optional head-of-line watchdog enabled by defining CXU_INIT_TIMEOUT_EN.
module cxu_l2_initiator #(
    parameter int N_CXUS         = 2,
    parameter int N_STATES       = 1,
    parameter int FUNC_ID_W      = 10,
    parameter int DATA_W         = 32,
    parameter int ROB_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    cxu_l2_initiator_if.master bus
);
    localparam int CXU_ID_W   = (N_CXUS > 1) ? $clog2(N_CXUS) : 1;
    localparam int STATE_ID_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;
    localparam int ID_W       = $clog2(ROB_DEPTH);
    localparam logic [ID_W:0] DEPTH_C = (ID_W+1)'(ROB_DEPTH);

    logic [ID_W-1:0]                  head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]                    count_q, count_d;
    logic [ROB_DEPTH-1:0]             done_q, status_q;
    logic [ROB_DEPTH-1:0][DATA_W-1:0] data_q;

    logic                  req_valid_q;
    logic [ID_W-1:0]       req_id_q;
    logic [CXU_ID_W-1:0]   req_cxu_q;
    logic [STATE_ID_W-1:0] req_state_q;
    logic [FUNC_ID_W-1:0]  req_func_q;
    logic [DATA_W-1:0]     req_data0_q, req_data1_q;
    logic                  err_q;

    logic            accept, pop, resp_hit, head_hit, to_fire;
    logic [ID_W-1:0] resp_off;

    assign bus.cmd_ready  = (count_q < DEPTH_C) && (!req_valid_q || bus.req_ready);
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign bus.res_valid  = (count_q != '0) && done_q[head_q];
    assign bus.res_data   = data_q[head_q];
    assign bus.res_status = status_q[head_q];
    assign pop            = bus.res_valid && bus.res_ready;

    // Tag is live iff its distance from head (mod depth) is below the occupancy.
    assign resp_off = bus.resp_id - head_q;
    assign resp_hit = bus.resp_valid && ({1'b0, resp_off} < count_q) && !done_q[bus.resp_id];
    assign head_hit = resp_hit && (bus.resp_id == head_q);

    assign bus.resp_ready     = 1'b1;
    assign bus.err_unexpected = err_q;
    assign bus.req_valid      = req_valid_q;
    assign bus.req_id         = req_id_q;
    assign bus.req_cxu        = req_cxu_q;
    assign bus.req_state      = req_state_q;
    assign bus.req_func       = req_func_q;
    assign bus.req_data0      = req_data0_q;
    assign bus.req_data1      = req_data1_q;

    assign head_d = pop ? head_q + 1'b1 : head_q;
    assign tail_d = accept ? tail_q + 1'b1 : tail_q;

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef CXU_INIT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] timer_q, timer_d;
    logic            to_active;

    // A genuine head response in the firing cycle wins over the watchdog.
    assign to_active = (count_q != '0) && !done_q[head_q] && !head_hit;
    assign to_fire   = to_active && (timer_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign timer_d   = (to_active && !to_fire) ? timer_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign to_fire        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            done_q      <= '0;
            status_q    <= '0;
            data_q      <= '0;
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            req_cxu_q   <= '0;
            req_state_q <= '0;
            req_func_q  <= '0;
            req_data0_q <= '0;
            req_data1_q <= '0;
            err_q       <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;

            if (accept) begin
                req_valid_q <= 1'b1;
                req_id_q    <= tail_q;
                req_cxu_q   <= bus.cmd_cxu;
                req_state_q <= bus.cmd_state;
                req_func_q  <= bus.cmd_func;
                req_data0_q <= bus.cmd_data0;
                req_data1_q <= bus.cmd_data1;
            end else if (bus.req_ready) begin
                req_valid_q <= 1'b0;
            end

            if (pop) done_q[head_q] <= 1'b0;

            if (resp_hit) begin
                done_q[bus.resp_id]   <= 1'b1;
                status_q[bus.resp_id] <= bus.resp_status;
                data_q[bus.resp_id]   <= bus.resp_data;
            end else if (bus.resp_valid) begin
                err_q <= 1'b1;
            end

            if (to_fire) begin
                done_q[head_q]   <= 1'b1;
                status_q[head_q] <= 1'b1;
                data_q[head_q]   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cxu_l2_initiator.sv
// Scoreboard bench for cxu_l2_initiator: mux2/mulacc-style responder (cxu0 = a*b in 1 cycle, cxu1 = a+b in 5).
module tb_cxu_l2_initiator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cxu_l2_initiator_if #(.N_CXUS(2), .N_STATES(1), .FUNC_ID_W(10), .DATA_W(32), .ROB_DEPTH(4)) bus ();

    cxu_l2_initiator #(
        .N_CXUS(2), .N_STATES(1), .FUNC_ID_W(10), .DATA_W(32), .ROB_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic        st;
        logic [31:0] d;
    } pend_t;

    pend_t       pend[$];
    logic [32:0] exp_q[$];
    logic [1:0]  tag_q[$];

    int n_vec = 0, n_err = 0, cyc_n = 0, budget = 0;
    int resp_drv_cyc = -1, res_rise_cyc = -1, acc_cyc = -1;
    logic [1:0] next_tag = '0, inj_id = '0;
    bit res_prev, acc, popd, pop_cr, inj_req, rq_rand, rr_rand, to_mode;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic cxu, input logic [9:0] func,
                                          input logic [31:0] a, input logic [31:0] b);
        return {func == 10'h3FF, cxu ? a + b : a * b};
    endfunction

    task automatic clr_model();
        exp_q.delete();
        tag_q.delete();
        pend.delete();
        next_tag = '0;
        res_prev = 1'b0;
    endtask

    // One clock: drive responder at the falling edge, observe handshakes just after, advance.
    task automatic cyc();
        logic [32:0] r, e;
        bus.resp_valid = 1'b0;
        if (rq_rand) bus.req_ready = 1'($urandom_range(0, 1));
        if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
        if (inj_req) begin
            bus.resp_valid  = 1'b1;
            bus.resp_id     = inj_id;
            bus.resp_status = 1'b0;
            bus.resp_data   = 32'hDEAD_BEEF;
            inj_req = 1'b0;
        end else if (budget > 0) begin
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].due <= cyc_n) begin
                    bus.resp_valid  = 1'b1;
                    bus.resp_id     = pend[i].id;
                    bus.resp_status = pend[i].st;
                    bus.resp_data   = pend[i].d;
                    pend.delete(i);
                    budget--;
                    resp_drv_cyc = cyc_n;
                    break;
                end
            end
        end
        #1;
        acc = bus.cmd_valid && bus.cmd_ready;
        if (acc) begin
            exp_q.push_back(to_mode ? 33'h1_0000_0000
                                    : model(bus.cmd_cxu, bus.cmd_func, bus.cmd_data0, bus.cmd_data1));
            tag_q.push_back(next_tag);
            next_tag++;
            acc_cyc = cyc_n;
        end
        if (bus.req_valid && bus.req_ready) begin
            if (tag_q.size() == 0) chk("req_extra", 64'(tag_q.size()), 1);
            else chk("req_id", bus.req_id, tag_q.pop_front());
            r = model(bus.req_cxu, bus.req_func, bus.req_data0, bus.req_data1);
            pend.push_back('{cyc_n + (bus.req_cxu ? 5 : 1), bus.req_id, r[32], r[31:0]});
        end
        popd = bus.res_valid && bus.res_ready;
        if (popd) begin
            pop_cr = bus.cmd_ready;
            if (exp_q.size() == 0) chk("res_extra", 64'(exp_q.size()), 1);
            else begin
                e = exp_q.pop_front();
                chk("res_data", bus.res_data, e[31:0]);
                chk("res_status", bus.res_status, e[32]);
            end
        end
        if (bus.res_valid && !res_prev) res_rise_cyc = cyc_n;
        res_prev = bus.res_valid;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic send(input logic cxu, input logic [9:0] func, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_cxu   = cxu;
        bus.cmd_state = 1'b0;
        bus.cmd_func  = func;
        bus.cmd_data0 = a;
        bus.cmd_data1 = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            cyc();
            ok = acc;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("send_stall", 64'(ok), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) cyc();
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    initial begin
        int c0;
        logic [1:0] t;
        bit got;
        bus.cmd_valid = 1'b0; bus.cmd_cxu = '0; bus.cmd_state = '0; bus.cmd_func = '0;
        bus.cmd_data0 = '0; bus.cmd_data1 = '0;
        bus.res_ready = 1'b1; bus.req_ready = 1'b1;
        bus.resp_valid = 1'b0; bus.resp_id = '0; bus.resp_status = 1'b0; bus.resp_data = '0;
        @(negedge clk);
        repeat (3) cyc();

        // Reset values
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_err", bus.err_unexpected, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_req_data0", bus.req_data0, 0);
        rst_n = 1'b1;
        cyc();
        chk("resp_ready", bus.resp_ready, 1);

        // Single command, 3*4 on cxu0
        budget = 1000;
        send(1'b0, 10'd1, 32'd3, 32'd4);
        drain();
        chk("t1_latency", 64'(res_rise_cyc - resp_drv_cyc), 1);

        // A slow (cxu1) then B fast (cxu0): B completes first but must wait for A
        send(1'b1, 10'd2, 32'd7, 32'd8);
        send(1'b0, 10'd2, 32'd2, 32'd3);
        repeat (3) cyc();
        chk("t2_b_held", bus.res_valid, 0);
        drain();

        // Fill the ROB with a silent responder; tags wrap 3 -> 0
        budget = 0;
        c0 = cyc_n;
        for (int i = 0; i < 4; i++) send(1'(i), 10'd5, 32'(i + 1), 32'd10);
        chk("t3_tput", 64'(cyc_n - c0), 4);
        chk("t3_full", bus.cmd_ready, 0);
        budget = 1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            got = popd;
        end
        chk("t3_popped", 64'(got), 1);
        chk("t3_no_bypass", pop_cr, 0);
        chk("t3_ready_after_pop", bus.cmd_ready, 1);
        budget = 1000;
        drain();

        // Response to an unallocated tag
        budget = 0;
        t = next_tag;
        send(1'b0, 10'd4, 32'd6, 32'd7);
        inj_req = 1'b1;
        inj_id  = t + 2'd2;
        cyc();
        cyc();
        chk("unexp_err", bus.err_unexpected, 1);
        chk("unexp_no_res", bus.res_valid, 0);
        repeat (3) cyc();
        chk("unexp_sticky", bus.err_unexpected, 1);
        budget = 1000;
        drain();
        chk("unexp_sticky2", bus.err_unexpected, 1);

        // Asynchronous reset with three in flight
        budget = 0;
        for (int i = 0; i < 3; i++) send(1'b1, 10'd3, 32'(i), 32'd1);
        rst_n = 1'b0;
        clr_model();
        #1;
        chk("arst_req_valid", bus.req_valid, 0);
        chk("arst_res_valid", bus.res_valid, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        chk("arst_err", bus.err_unexpected, 0);
        chk("arst_req_data0", bus.req_data0, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        budget = 1000;
        send(1'b1, 10'd9, 32'd5, 32'd6);
        chk("arst_req_id", bus.req_id, 0);
        drain();

        // Random burst with back-pressure on both sides
        rq_rand = 1'b1;
        rr_rand = 1'b1;
        budget  = 1000;
        for (int i = 0; i < 24; i++)
            send(1'($urandom_range(0, 1)), (i % 7 == 3) ? 10'h3FF : 10'($urandom_range(0, 1022)),
                 $urandom, $urandom);
        rq_rand = 1'b0;
        rr_rand = 1'b0;
        bus.req_ready = 1'b1;
        bus.res_ready = 1'b1;
        drain();

`ifdef CXU_INIT_TIMEOUT_EN
        // Watchdog: silent responder, then the late genuine response
        rst_n = 1'b0;
        clr_model();
        cyc();
        rst_n = 1'b1;
        cyc();
        budget  = 0;
        to_mode = 1'b1;
        send(1'b0, 10'd5, 32'd1, 32'd1);
        to_mode = 1'b0;
        drain();
        chk("to_rise", 64'(res_rise_cyc - (acc_cyc + 1)), 8);
        chk("to_err_before", bus.err_unexpected, 0);
        budget = 1;
        repeat (3) cyc();
        chk("to_late_err", bus.err_unexpected, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
